pulse_cmd_issuer: RTL and testbench

PULSE_CMD_ISSUER -- requirements
Module: pulse_cmd_issuer

---
 rtl/pulse_cmd_issuer.sv | 148 ++++++++++++++
 tb/tb_pulse_cmd_issuer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_issuer.sv
// Pulse command issuer: queues {length, id} commands and sequences them into a
// downstream length counter, reporting completion by tag; supports abort and reset.
module pulse_cmd_issuer #(
    parameter int LENGTH_WIDTH = 7,
    parameter int ID_WIDTH     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    input  logic [LENGTH_WIDTH-1:0]         cmd_length,
    input  logic [ID_WIDTH-1:0]             cmd_id,
    output logic                            cmd_ready,
    input  logic                            abort,
    input  logic                            counter_running,
    output logic                            set_counter,
    output logic [LENGTH_WIDTH-1:0]         length_out,
    output logic                            pulse_done,
    output logic [ID_WIDTH-1:0]             done_id,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = LENGTH_WIDTH + ID_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        KILL = 2'd3
    } state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [LENGTH_WIDTH-1:0] cur_len_q, cur_len_d;
    logic [ID_WIDTH-1:0]     cur_id_q, cur_id_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic abort_act;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cur_len_d   = cur_len_q;
        cur_id_d    = cur_id_q;
        pop         = 1'b0;
        set_counter = 1'b0;
        length_out  = '0;
        pulse_done  = 1'b0;
        done_id     = '0;

        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        abort_act = abort && (state_q != KILL);
        cmd_ready = !full && !abort && (state_q != KILL);
        push      = cmd_valid && cmd_ready;

        case (state_q)
            IDLE: begin
                if (abort_act) begin
                    state_d = KILL;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                set_counter = 1'b1;
                length_out  = cur_len_q;
                state_d     = abort_act ? KILL : BUSY;
            end
            BUSY: begin
                if (abort_act) begin
                    state_d = KILL;
                end else if (!counter_running) begin
                    pulse_done = 1'b1;
                    done_id    = cur_id_q;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                // Zero-length load parks the downstream counter after an abort.
                set_counter = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            {cur_len_d, cur_id_d} = mem[rd_ptr_q];
        end

        if (abort_act) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cur_len_q <= '0;
            cur_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cur_len_q <= cur_len_d;
            cur_id_q  <= cur_id_d;
        end
    end

    // Queue storage has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= {cmd_length, cmd_id};
        end
    end

    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_pulse_cmd_issuer.sv
// Directed bench for pulse_cmd_issuer with a behavioural downstream down-counter.
module tb_pulse_cmd_issuer;

    localparam int LW = 7;
    localparam int IW = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [LW-1:0] cmd_length;
    logic [IW-1:0] cmd_id;
    logic          cmd_ready;
    logic          abort;
    logic          counter_running;
    logic          set_counter;
    logic [LW-1:0] length_out;
    logic          pulse_done;
    logic [IW-1:0] done_id;
    logic          busy;
    logic [2:0]    fifo_count;

    logic [LW-1:0] cnt = '0;

    int errors = 0;
    int checks = 0;

    pulse_cmd_issuer #(.LENGTH_WIDTH(LW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_length(cmd_length),
        .cmd_id(cmd_id), .cmd_ready(cmd_ready), .abort(abort),
        .counter_running(counter_running), .set_counter(set_counter),
        .length_out(length_out), .pulse_done(pulse_done), .done_id(done_id),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Downstream counter: loads on set_counter, counts down to zero.
    always @(posedge clk) begin
        if (set_counter) cnt <= length_out;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign counter_running = (cnt != '0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, "_set_counter"}, 32'(set_counter), 0);
        check({tag, "_length_out"}, 32'(length_out), 0);
        check({tag, "_pulse_done"}, 32'(pulse_done), 0);
        check({tag, "_done_id"}, 32'(done_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
    endtask

    initial begin
        int exp_strobe [4];
        int exp_done [4];
        int ns;
        int nd;
        int seen;
        int strobes;
        int dones;

        rst = 1'b1; cmd_valid = 1'b0; cmd_length = '0; cmd_id = '0; abort = 1'b0;
        tick(); tick(); tick();
        settle();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single command L=5 id=3 accepted in cycle T
        cmd_valid = 1'b1; cmd_length = 7'd5; cmd_id = 4'd3;
        settle();
        check("single_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        settle();
        check("single_t1_count", 32'(fifo_count), 1);
        check("single_t1_setc", 32'(set_counter), 0);
        tick();
        check("single_t2_setc", 32'(set_counter), 1);
        check("single_t2_len", 32'(length_out), 5);
        check("single_t2_busy", 32'(busy), 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("single_wait_done", 32'(pulse_done), 0);
            check("single_wait_setc", 32'(set_counter), 0);
            tick();
        end
        check("single_t8_done", 32'(pulse_done), 1);
        check("single_t8_id", 32'(done_id), 3);
        tick();
        check("single_t9_done", 32'(pulse_done), 0);
        check("single_t9_id", 32'(done_id), 0);
        check("single_t9_busy", 32'(busy), 0);

        // Stream of four L=2 commands, ids 1..4
        exp_strobe = '{2, 6, 10, 14};
        exp_done   = '{5, 9, 13, 17};
        ns = 0; nd = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 4) begin
                cmd_valid = 1'b1; cmd_length = 7'd2; cmd_id = IW'(c + 1);
            end else begin
                cmd_valid = 1'b0;
            end
            settle();
            if (c < 4) check("stream_ready", 32'(cmd_ready), 1);
            if (set_counter) begin
                if (ns < 4) check("stream_strobe_cycle", 32'(c), 32'(exp_strobe[ns]));
                ns++;
            end
            if (pulse_done) begin
                if (nd < 4) begin
                    check("stream_done_cycle", 32'(c), 32'(exp_done[nd]));
                    check("stream_done_id", 32'(done_id), 32'(nd + 1));
                end
                nd++;
            end
            tick();
        end
        check("stream_strobes", 32'(ns), 4);
        check("stream_dones", 32'(nd), 4);

        // Fill the queue behind a long pulse
        cmd_valid = 1'b1; cmd_length = 7'd100; cmd_id = 4'd0;
        settle();
        check("full_first_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("full_busy", 32'(busy), 1);
        check("full_empty", 32'(fifo_count), 0);
        for (int k = 1; k <= 4; k++) begin
            cmd_valid = 1'b1; cmd_length = 7'd1; cmd_id = IW'(k);
            settle();
            check("full_push_ready", 32'(cmd_ready), 1);
            tick();
        end
        cmd_valid = 1'b1; cmd_length = 7'd1; cmd_id = 4'd5;
        settle();
        check("full_count4", 32'(fifo_count), 4);
        check("full_not_ready", 32'(cmd_ready), 0);
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (pulse_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("full_wait_done", 32'(seen), 1);
        check("full_done_id", 32'(done_id), 0);
        check("full_done_not_ready", 32'(cmd_ready), 0);
        tick();
        check("full_load_setc", 32'(set_counter), 1);
        check("full_load_len", 32'(length_out), 1);
        check("full_after_pop_count", 32'(fifo_count), 3);
        check("full_after_pop_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        settle();
        check("full_fifth_accepted", 32'(fifo_count), 4);

        // Abort in the would-be completion cycle with a push offered
        tick();
        abort = 1'b1; cmd_valid = 1'b1; cmd_length = 7'd3; cmd_id = 4'd9;
        settle();
        check("abort_ready", 32'(cmd_ready), 0);
        check("abort_no_done", 32'(pulse_done), 0);
        tick();
        check("kill_count", 32'(fifo_count), 0);
        check("kill_setc", 32'(set_counter), 1);
        check("kill_len", 32'(length_out), 0);
        check("kill_busy", 32'(busy), 1);
        check("kill_ready", 32'(cmd_ready), 0);
        check("kill_no_done", 32'(pulse_done), 0);
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        settle();
        check("post_kill_busy", 32'(busy), 0);
        check("post_kill_count", 32'(fifo_count), 0);
        check("post_kill_setc", 32'(set_counter), 0);
        strobes = 0; dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            strobes += 32'(set_counter);
            dones += 32'(pulse_done);
        end
        check("post_kill_strobes", 32'(strobes), 0);
        check("post_kill_dones", 32'(dones), 0);

        // Zero-length command
        cmd_valid = 1'b1; cmd_length = 7'd0; cmd_id = 4'd7;
        settle();
        tick();
        cmd_valid = 1'b0;
        tick();
        check("zero_setc", 32'(set_counter), 1);
        check("zero_len", 32'(length_out), 0);
        check("zero_load_no_done", 32'(pulse_done), 0);
        tick();
        check("zero_done", 32'(pulse_done), 1);
        check("zero_id", 32'(done_id), 7);
        tick();
        check("zero_idle", 32'(busy), 0);

        // Reset mid-pulse with two queued, abort and push also asserted
        for (int k = 1; k <= 3; k++) begin
            cmd_valid = 1'b1; cmd_length = 7'd10; cmd_id = IW'(k);
            settle();
            tick();
        end
        cmd_valid = 1'b0;
        settle();
        check("rstmid_busy", 32'(busy), 1);
        check("rstmid_count", 32'(fifo_count), 2);
        rst = 1'b1; abort = 1'b1; cmd_valid = 1'b1;
        tick();
        rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
        settle();
        check_reset_outputs("rstmid");
        strobes = 0; dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            strobes += 32'(set_counter);
            dones += 32'(pulse_done);
        end
        check("rstmid_no_strobes", 32'(strobes), 0);
        check("rstmid_no_dones", 32'(dones), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
